// File: rtl/regfile_mp.sv
// Multi-read-port register file with one synchronous write port, optional
// write-to-read bypass, optional hardwired-zero entry 0 and a per-entry busy
// scoreboard. After reset a sweep zeroes one entry per cycle, so the storage
// never needs a parallel reset and can map onto RAM.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rbsy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     bsy_set,
  input  logic [ADDR_W-1:0]        bsy_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_ready;
  logic              wr_ok;
  logic              set_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign in_ready = (state_q == ST_READY);
  assign ready    = in_ready;

  // Entry 0 is excluded from writes and busy sets when it is hardwired to zero.
  assign wr_ok  = in_ready && we && !((ZERO_REG != 0) && (wa == '0));
  assign set_ok = in_ready && bsy_set && !((ZERO_REG != 0) && (bsy_addr == '0));

  // Sweep sequencer: walk cnt across every entry, then go READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_READY;
      end
    end
  end

  // Control state and busy scoreboard, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Busy update: a write retires its producer; a same-cycle set overrides
  // the clear because a newer producer has just issued.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wa] = 1'b0;
    end
    if (set_ok) begin
      busy_d[bsy_addr] = 1'b1;
    end
  end

  // Single storage write port shared by the clear sweep and normal writes;
  // a write in a reset cycle is discarded.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wa;
    mem_wd = wd;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = cnt_q[ADDR_W-1:0];
        mem_wd = '0;
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array, no reset so it can be implemented as RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Combinational read ports. Outputs are forced to zero until the sweep
  // has finished, since entries not yet swept may hold stale data.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              zero_hit;
      logic              byp_hit;
      logic [DATA_W-1:0] data;
      logic              bsy;

      assign addr     = ra[gi*ADDR_W +: ADDR_W];
      assign zero_hit = (ZERO_REG != 0) && (addr == '0);
      assign byp_hit  = (BYPASS != 0) && in_ready && we && (wa == addr);

      // Select bypass, storage or zero for this port.
      always_comb begin
        data = '0;
        bsy  = 1'b0;
        if (in_ready && !zero_hit) begin
          if (byp_hit) begin
            data = wd;
            bsy  = bsy_set && (bsy_addr == addr);
          end else begin
            data = mem[addr];
            bsy  = busy_q[addr];
          end
        end
      end

      assign rd[gi*DATA_W +: DATA_W] = data;
      assign rbsy[gi]                = bsy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (32x32, 2 ports, zero reg, bypass)
// and a small instance (8x8, 4 ports, no zero reg, no bypass). Each has an
// entry-level behavioural model; every cycle all outputs are compared with it.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance A: default parameters
  logic        a_reset, a_ready, a_we, a_bsy_set;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic [1:0]  a_rbsy;
  logic [4:0]  a_wa, a_bsy_addr;
  logic [31:0] a_wd;

  regfile_mp dut_a (
    .clk(clk), .reset(a_reset), .ready(a_ready), .ra(a_ra), .rd(a_rd),
    .rbsy(a_rbsy), .we(a_we), .wa(a_wa), .wd(a_wd), .bsy_set(a_bsy_set),
    .bsy_addr(a_bsy_addr)
  );

  // Instance B: small, four ports, entry 0 writable, no bypass
  logic        b_reset, b_ready, b_we, b_bsy_set;
  logic [11:0] b_ra;
  logic [31:0] b_rd;
  logic [3:0]  b_rbsy;
  logic [2:0]  b_wa, b_bsy_addr;
  logic [7:0]  b_wd;

  regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(b_reset), .ready(b_ready), .ra(b_ra), .rd(b_rd),
    .rbsy(b_rbsy), .we(b_we), .wa(b_wa), .wd(b_wd), .bsy_set(b_bsy_set),
    .bsy_addr(b_bsy_addr)
  );

  // Reference models: contents, busy flags, edges left before ready.
  logic [31:0] ma_mem [32];
  bit          ma_bsy [32];
  int          ma_left = 32;
  logic [7:0]  mb_mem [8];
  bit          mb_bsy [8];
  int          mb_left = 8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    chk("a_ready", 32'(a_ready), 32'(ma_left == 0));
    for (int p = 0; p < 2; p++) begin
      int ad;
      logic [31:0] ed;
      bit eb;
      ad = int'(a_ra[p*5 +: 5]);
      if (ma_left != 0 || ad == 0) begin
        ed = '0; eb = 1'b0;
      end else if (a_we && int'(a_wa) == ad) begin
        ed = a_wd; eb = a_bsy_set && int'(a_bsy_addr) == ad;
      end else begin
        ed = ma_mem[ad]; eb = ma_bsy[ad];
      end
      chk($sformatf("a_rd%0d[%0d]", p, ad), a_rd[p*32 +: 32], ed);
      chk($sformatf("a_rbsy%0d[%0d]", p, ad), 32'(a_rbsy[p]), 32'(eb));
    end
  endtask

  task automatic check_b();
    chk("b_ready", 32'(b_ready), 32'(mb_left == 0));
    for (int p = 0; p < 4; p++) begin
      int ad;
      logic [7:0] ed;
      bit eb;
      ad = int'(b_ra[p*3 +: 3]);
      if (mb_left != 0) begin
        ed = '0; eb = 1'b0;
      end else begin
        ed = mb_mem[ad]; eb = mb_bsy[ad];
      end
      chk($sformatf("b_rd%0d[%0d]", p, ad), 32'(b_rd[p*8 +: 8]), 32'(ed));
      chk($sformatf("b_rbsy%0d[%0d]", p, ad), 32'(b_rbsy[p]), 32'(eb));
    end
  endtask

  task automatic update_a();
    if (a_reset) begin
      ma_left = 32;
      for (int i = 0; i < 32; i++) begin ma_mem[i] = '0; ma_bsy[i] = 1'b0; end
    end else if (ma_left > 0) begin
      ma_left--;
    end else begin
      if (a_we && a_wa != 0) begin ma_mem[a_wa] = a_wd; ma_bsy[a_wa] = 1'b0; end
      if (a_bsy_set && a_bsy_addr != 0) ma_bsy[a_bsy_addr] = 1'b1;
    end
  endtask

  task automatic update_b();
    if (b_reset) begin
      mb_left = 8;
      for (int i = 0; i < 8; i++) begin mb_mem[i] = '0; mb_bsy[i] = 1'b0; end
    end else if (mb_left > 0) begin
      mb_left--;
    end else begin
      if (b_we) begin mb_mem[b_wa] = b_wd; mb_bsy[b_wa] = 1'b0; end
      if (b_bsy_set) mb_bsy[b_bsy_addr] = 1'b1;
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change 1 ns after rising.
  task automatic settle();
    @(negedge clk);
    check_a();
    check_b();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    update_a();
    update_b();
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin settle(); clk_edge(); end
  endtask

  task automatic a_idle();
    a_we = 1'b0; a_bsy_set = 1'b0; a_wa = '0; a_wd = '0; a_bsy_addr = '0;
  endtask

  task automatic a_rand();
    a_we       = 1'($urandom_range(0, 1));
    a_wa       = 5'($urandom);
    a_wd       = $urandom;
    a_bsy_set  = 1'($urandom_range(0, 1));
    a_bsy_addr = 5'($urandom);
    for (int p = 0; p < 2; p++) begin
      case ($urandom_range(0, 3))
        0: a_ra[p*5 +: 5] = a_wa;
        1: a_ra[p*5 +: 5] = a_bsy_addr;
        2: a_ra[p*5 +: 5] = 5'($urandom);
        default: a_ra[p*5 +: 5] = '0;
      endcase
    end
  endtask

  task automatic b_rand();
    b_we       = 1'($urandom_range(0, 1));
    b_wa       = 3'($urandom);
    b_wd       = 8'($urandom);
    b_bsy_set  = 1'($urandom_range(0, 1));
    b_bsy_addr = 3'($urandom);
    for (int p = 0; p < 4; p++) b_ra[p*3 +: 3] = 3'($urandom);
  endtask

  initial begin
    a_reset = 1'b1; a_ra = '0; a_idle();
    b_reset = 1'b1; b_ra = '0; b_we = 1'b0; b_wa = '0; b_wd = '0;
    b_bsy_set = 1'b0; b_bsy_addr = '0;
    clk_edge();
    tick(2);
    a_reset = 1'b0; b_reset = 1'b0;

    // Sweep: writes and busy sets are thrown at both ports and must be lost
    for (int i = 0; i < 32; i++) begin a_rand(); tick(1); end
    a_idle();
    for (int i = 0; i < 32; i++) begin
      a_ra = {5'(31 - i), 5'(i)};
      tick(1);
    end

    // Write / read back, entry 0 hardwired
    a_we = 1'b1; a_wa = 5'd5;  a_wd = 32'hDEADBEEF; tick(1);
    a_wa = 5'd31; a_wd = 32'h12345678; tick(1);
    a_idle(); a_ra = {5'd31, 5'd5};
    settle();
    chk("wr5", a_rd[31:0], 32'hDEADBEEF);
    chk("wr31", a_rd[63:32], 32'h12345678);
    clk_edge();
    a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFFFFFF; a_ra = '0; tick(1);
    a_idle();
    settle();
    chk("zero_reg", a_rd[31:0], 32'h0);
    clk_edge();

    // Bypass to both ports
    a_we = 1'b1; a_wa = 5'd7; a_wd = 32'hA5A5A5A5; a_ra = {5'd7, 5'd7};
    settle();
    chk("byp0", a_rd[31:0], 32'hA5A5A5A5);
    chk("byp1", a_rd[63:32], 32'hA5A5A5A5);
    clk_edge();
    a_idle();

    // Scoreboard
    a_bsy_set = 1'b1; a_bsy_addr = 5'd9; a_ra = {5'd9, 5'd9}; tick(1);
    a_bsy_set = 1'b0;
    settle(); chk("bsy9_set", 32'(a_rbsy[0]), 32'd1); clk_edge();
    a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h99;
    settle(); chk("bsy9_byp", 32'(a_rbsy[0]), 32'd0); clk_edge();
    a_we = 1'b0;
    settle(); chk("bsy9_clr", 32'(a_rbsy[1]), 32'd0); clk_edge();
    a_we = 1'b1; a_bsy_set = 1'b1; a_bsy_addr = 5'd9; tick(1);
    a_idle();
    settle(); chk("bsy9_win", 32'(a_rbsy[0]), 32'd1); clk_edge();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      a_rand();
      a_reset = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    a_reset = 1'b0; a_idle();
    tick(33);

    // Reset during a sweep
    a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h55; a_bsy_set = 1'b1; a_bsy_addr = 5'd4;
    tick(1);
    a_idle(); a_reset = 1'b1; tick(1);
    a_reset = 1'b0; tick(10);
    a_reset = 1'b1; tick(1);
    a_reset = 1'b0; a_ra = {5'd4, 5'd3};
    tick(31);
    settle(); chk("rst_ready_lo", 32'(a_ready), 32'd0); clk_edge();
    settle();
    chk("rst_ready_hi", 32'(a_ready), 32'd1);
    chk("rst_e3", a_rd[31:0], 32'h0);
    chk("rst_b4", 32'(a_rbsy[1]), 32'd0);
    clk_edge();

    // Small instance: 8-edge sweep
    b_reset = 1'b1; tick(1);
    b_reset = 1'b0; tick(7);
    settle(); chk("b_sweep7", 32'(b_ready), 32'd0); clk_edge();
    settle(); chk("b_sweep8", 32'(b_ready), 32'd1); clk_edge();
    b_we = 1'b1; b_wa = 3'd0; b_wd = 8'h3C; tick(1);
    b_we = 1'b0; b_ra = '0;
    settle(); chk("b_e0", 32'(b_rd[7:0]), 32'h3C); clk_edge();
    for (int i = 1; i < 8; i++) begin
      b_we = 1'b1; b_wa = 3'(i); b_wd = 8'(8'h10 + i); tick(1);
    end
    b_we = 1'b0; b_ra = {3'd4, 3'd3, 3'd2, 3'd1};
    settle();
    for (int p = 0; p < 4; p++)
      chk($sformatf("b_port%0d", p), 32'(b_rd[p*8 +: 8]), 32'(8'h11 + p));
    clk_edge();
    b_we = 1'b1; b_wa = 3'd7; b_wd = 8'hA5; b_ra = {4{3'd7}};
    settle(); chk("b_nobyp_old", 32'(b_rd[31:24]), 32'h17); clk_edge();
    b_we = 1'b0;
    settle(); chk("b_nobyp_new", 32'(b_rd[7:0]), 32'hA5); clk_edge();
    for (int i = 0; i < 300; i++) begin b_rand(); tick(1); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, the next generation of the single-port `regfile`. It has N combinational read ports and one synchronous write port, with optional write-to-read bypass and an optional hardwired-zero register 0. A per-entry busy scoreboard supports pipelined hazard checks. A post-reset clear sweep zeroes the array one entry per cycle, so the storage can map to RAM without a parallel reset. It sits between decode (reads, busy checks) and writeback (writes, busy clears) in the core pipeline.

## Interface

Parameters:
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 always reads 0, is never written and is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ready  out  1  high once the clear sweep completes
- ra  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rbsy  out  NUM_RD  busy flag of the entry addressed by each read port
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- bsy_set  in  1  mark entry bsy_addr busy (producer issued)
- bsy_addr  in  ADDR_W  entry to mark busy

## Operation

- States: CLEAR and READY. A sweep counter cnt of ADDR_W+1 bits runs in CLEAR.
- Reset (clk edge with reset=1):
  - state <= CLEAR, cnt <= 0, all busy bits <= 0.
  - Array contents are not touched directly.
- CLEAR, reset=0:
  - Each edge writes mem[cnt] <= 0 and cnt <= cnt+1.
  - When cnt == DEPTH-1, state <= READY.
  - we and bsy_set are ignored.
  - rd = 0 and rbsy = 0 on every port.
- READY, write path:
  - we=1 writes mem[wa] <= wd and clears busy[wa].
  - If ZERO_REG and wa==0, the write is dropped.
- READY, busy set:
  - bsy_set=1 sets busy[bsy_addr].
  - If ZERO_REG and bsy_addr==0, the set is dropped.
- Simultaneous we and bsy_set to the same address: data is written and busy ends at 1 (set wins; a new producer is in flight).
- Read port k (combinational):
  - ZERO_REG and ra_k==0: rd_k=0, rbsy_k=0.
  - Else, if BYPASS, we=1 and wa==ra_k: rd_k=wd. rbsy_k is 1 only if bsy_set=1 and bsy_addr==ra_k, else 0.
  - Else: rd_k=mem[ra_k], rbsy_k=busy[ra_k].
- With BYPASS=0, reads return pre-edge contents and busy state; the written value appears the cycle after the edge.
- Multiple read ports may address the same entry and return identical values.
- Reset asserted mid-sweep or during READY: takes effect at the next edge and restarts the sweep at entry 0. Any write in that cycle is discarded.

## Timing

- Reads: zero-cycle combinational latency from ra/we/wa/wd.
- Writes and busy updates: committed at the rising edge where enabled.
- ready = 0 from the reset edge through the sweep.
- Reset is released before edge 1. ready rises after edge DEPTH (32 edges with defaults). The first accepted write is at edge DEPTH+1.
- Reset values of outputs: ready=0, rd=0, rbsy=0.
- No back-pressure. The caller must hold off writes until ready=1; writes earlier are lost.

## Test plan

- Reset sweep: hold reset for 3 cycles, release. ready must stay 0 for exactly 32 edges. After that, reading all 32 addresses on both ports returns 0 and rbsy=0. Writes with we=1 during the sweep must leave no effect.
- Write/read: write 0xDEADBEEF to entry 5 and 0x12345678 to entry 31. Next cycle, ra0=5 and ra1=31 return those values. Writing 0xFFFFFFFF to entry 0 still reads 0.
- Bypass: we=1, wa=7, wd=0xA5A5A5A5 with ra0=ra1=7. Both rd show 0xA5A5A5A5 in the same cycle. With BYPASS=0 they show the old value that cycle and the new value the next.
- Scoreboard: bsy_set to entry 9, then rbsy for 9 = 1. A write to 9 shows rbsy=0 in the same cycle (BYPASS=1) and the busy bit is cleared after the edge. bsy_set and we both to 9 in one cycle leave rbsy=1 afterwards.
- Reset mid-operation: write entry 3 = 0x55, set busy on 4, assert reset at sweep cnt=10 of a second sweep. The sweep restarts, ready stays 0 for 32 edges, then entry 3 reads 0 and entry 4 is not busy.
- Parameter sweep: NUM_RD=4, ADDR_W=3, DATA_W=8, ZERO_REG=0. The sweep lasts 8 edges. Entry 0 is writable (0x3C reads back). All 4 ports independently read distinct entries.
